io_sched: RTL and testbench
===========================

IO_SCHED -- requirements
Module: io_sched

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter wire_width, default 3, SHALL be the number of lanes.
REQ-003 Parameter burst_len, default 4, range 1..15, SHALL be the maximum XFER cycles per grant.
REQ-004 Port clk, input, 1 bit: the clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous active-high reset.
REQ-006 Port req, input, wire_width bits: per-lane transfer request.
REQ-007 Port dir, input, wire_width bits: per-lane direction; 1 = lane drives port, 0 = port drives lane.
REQ-008 Port gnt, output, wire_width bits: one-hot grant, all-zero when no lane owns the bus.
REQ-009 Port busy, output, 1 bit: high in any state other than IDLE.
REQ-010 Port select, output, 2*wire_width bits: lane x code on select[2x+1:2x], suitable for direct connection to the io_block select input.

Function
REQ-011 Select codes SHALL be 2'b00 = high-Z, 2'b01 = lane drives port, 2'b10 = port drives lane; 2'b11 SHALL never be emitted.
REQ-012 The state machine SHALL have states IDLE, TURN and XFER.
REQ-013 In IDLE, with any req bit high, the block SHALL pick the lowest-index requesting lane at or after the round-robin pointer, wrapping past wire_width-1 to 0.
REQ-014 On that edge the block SHALL register the winning lane index and its dir bit, then enter TURN.
REQ-015 IDLE with req all-zero SHALL stay in IDLE.
REQ-016 TURN SHALL last exactly one cycle, with select all-zero and gnt all-zero, then enter XFER.
REQ-017 In XFER, gnt SHALL be one-hot on the granted lane.
REQ-018 In XFER, select SHALL hold 01 or 10 for the granted lane per its registered dir, and 00 for every other lane.
REQ-019 A 4-bit beat counter SHALL clear on XFER entry and increment each XFER cycle.
REQ-020 XFER SHALL exit to IDLE after burst_len cycles.
REQ-021 XFER SHALL also exit to IDLE on the edge after the granted lane's req is sampled low (early termination); that cycle still counts as a beat.
REQ-022 Changes on dir during XFER SHALL be ignored; direction is fixed at grant time.
REQ-023 On XFER exit, the pointer SHALL move to (granted+1) mod wire_width.
REQ-024 Outputs SHALL be registered; at most one lane is non-zero in select in any cycle.
REQ-025 Requests arriving during TURN or XFER SHALL wait for the next IDLE; there is no queueing beyond the live req level.
REQ-026 Grant latency SHALL be 2 cycles from IDLE req sample to first XFER cycle, or 1 cycle without the turnaround feature.

Reset
REQ-027 When rst is sampled high on a clock edge: state <= IDLE, pointer <= 0, beat counter <= 0, gnt <= 0, busy <= 0, select <= all-zero.
REQ-028 Reset asserted mid-XFER SHALL return select to all-zero on the same edge, with no further beats.
REQ-029 Reset SHALL override all req activity.

Configuration
REQ-030 Macro IO_SCHED_TURNAROUND_EN SHALL control the turnaround cycle.
REQ-031 With IO_SCHED_TURNAROUND_EN defined, the TURN state SHALL exist as specified.
REQ-032 Without IO_SCHED_TURNAROUND_EN, TURN SHALL be omitted; IDLE SHALL go directly to XFER, and the one IDLE cycle between bursts SHALL remain the only bus-idle gap.

Verification
REQ-033 Basic burst: wire_width=3, burst_len=4, turnaround on; rst then req=001, dir=001 held -> TURN 1 cycle, then 4 cycles select=000001 and gnt=001, then IDLE with select=0.
REQ-034 Round-robin: req=111 held -> grants in order lane0, lane1, lane2, lane0; each burst is 4 beats with IDLE+TURN gaps between bursts.
REQ-035 Early termination: lane1 granted with dir=0, req[1] dropped after beat 2 -> select=001000 for exactly 2 beats, then IDLE; pointer = 2.
REQ-036 Mid-burst reset: rst asserted on beat 3 of a lane2 burst -> next cycle select=0, gnt=0, busy=0; with req=100 held, the next grant goes to lane2 from pointer 0.
REQ-037 Macro off: req=010, dir=010 -> XFER starts 1 cycle after sample, select=000100; 11 code never observed (assertion over whole run).
REQ-038 dir toggling during XFER -> select code for the granted lane unchanged for the whole burst.

Source files
------------

// File: rtl/io_sched.sv
// rtl/io_sched.sv - round-robin lane scheduler driving io_block select codes.
// Optional turnaround cycle between grant and transfer: define IO_SCHED_TURNAROUND_EN.
module io_sched #(
  parameter int wire_width = 3,
  parameter int burst_len  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [wire_width-1:0]     req,
  input  logic [wire_width-1:0]     dir,
  output logic [wire_width-1:0]     gnt,
  output logic                      busy,
  output logic [2*wire_width-1:0]   select
);

  localparam int LW = (wire_width > 1) ? $clog2(wire_width) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, TURN = 2'd1, XFER = 2'd2} state_t;

  state_t                  state_q, state_d;
  logic [LW-1:0]           ptr_q, ptr_d;
  logic [LW-1:0]           lane_q, lane_d;
  logic                    dir_q, dir_d;
  logic [3:0]              beat_q, beat_d;
  logic [wire_width-1:0]   gnt_q, gnt_d;
  logic                    busy_q, busy_d;
  logic [2*wire_width-1:0] sel_q, sel_d;

  logic                    found;
  logic [LW-1:0]           win;
  int                      idx;

  // Rotating search: first requester at or after the pointer, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 0; i < wire_width; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= wire_width) idx = idx - wire_width;
      if (!found && req[LW'(idx)]) begin
        found = 1'b1;
        win   = LW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      lane_q  <= '0;
      dir_q   <= 1'b0;
      beat_q  <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lane_q  <= lane_d;
      dir_q   <= dir_d;
      beat_q  <= beat_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    lane_d  = lane_q;
    dir_d   = dir_q;
    beat_d  = beat_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          lane_d = win;
          dir_d  = dir[win];
          beat_d = '0;
`ifdef IO_SCHED_TURNAROUND_EN
          state_d = TURN;
`else
          state_d = XFER;
`endif
        end
      end
      TURN: begin
        beat_d  = '0;
        state_d = XFER;
      end
      XFER: begin
        // The cycle in which req drops is still a beat; exit on its closing edge.
        beat_d = beat_q + 4'd1;
        if (beat_q == 4'(burst_len - 1) || !req[lane_q]) begin
          state_d = IDLE;
          ptr_d   = (lane_q == LW'(wire_width - 1)) ? '0 : lane_q + LW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from next state so the registered copies line up with state_q.
  always_comb begin
    gnt_d  = '0;
    sel_d  = '0;
    busy_d = (state_d != IDLE);
    if (state_d == XFER) begin
      gnt_d[lane_d]              = 1'b1;
      sel_d[2*int'(lane_d) +: 2] = dir_d ? 2'b01 : 2'b10;
    end
  end

  assign gnt    = gnt_q;
  assign busy   = busy_q;
  assign select = sel_q;

endmodule

// File: tb/tb_io_sched.sv
// tb/tb_io_sched.sv - scoreboard bench for io_sched (default or IO_SCHED_TURNAROUND_EN build).
module tb_io_sched;

  localparam int W = 3;
  localparam int B = 4;
`ifdef IO_SCHED_TURNAROUND_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   req;
  logic [W-1:0]   dir;
  logic [W-1:0]   gnt;
  logic           busy;
  logic [2*W-1:0] select;

  io_sched #(.wire_width(W), .burst_len(B)) dut (
    .clk(clk), .rst(rst), .req(req), .dir(dir),
    .gnt(gnt), .busy(busy), .select(select)
  );

  always #5 clk = ~clk;

  typedef struct {
    int             cyc;
    logic [W-1:0]   g;
    logic [2*W-1:0] s;
  } beat_t;

  beat_t exp_q[$];
  beat_t e;
  int    cyc = 0;
  int    pass_cnt = 0;
  int    total_cnt = 0;
  int    illegal = 0;
  int    nz;
  int    k, s, s2, s3;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input bit ok, input string act, input string exp);
    total_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: got %s, expected %s", name, act, exp);
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_burst(input int start, input logic [W-1:0] g, input logic [2*W-1:0] sl, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back('{cyc: start + i, g: g, s: sl});
  endtask

  // Called just after a rising edge; samples at the falling edge, returns after the next rising edge.
  task automatic expect_idle(input string name);
    #4;
    check(name, gnt == '0 && select == '0 && busy == 1'b0,
          $sformatf("gnt=%b select=%b busy=%b", gnt, select, busy),
          "gnt=000 select=000000 busy=0");
    @(posedge clk);
    #1;
  endtask

  // Monitor: every granted cycle must match the next expected beat, cycle-exact.
  always @(negedge clk) begin
    nz = 0;
    for (int i = 0; i < W; i++) begin
      if (select[2*i +: 2] == 2'b11) illegal++;
      if (select[2*i +: 2] != 2'b00) nz++;
    end
    if (nz > 1) illegal++;
    if (gnt != '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 1'b0, $sformatf("cyc=%0d gnt=%b select=%b", cyc, gnt, select), "no beat");
      end else begin
        e = exp_q.pop_front();
        check("beat", cyc == e.cyc && gnt == e.g && select == e.s && busy == 1'b1,
              $sformatf("cyc=%0d gnt=%b select=%b busy=%b", cyc, gnt, select, busy),
              $sformatf("cyc=%0d gnt=%b select=%b busy=1", e.cyc, e.g, e.s));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000ns");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req = '0;
    dir = '0;
    wait_until(2);
    expect_idle("reset_state");
    rst = 1'b0;

    // Basic burst on lane 0, lane drives port.
    wait_until(4);
    k = cyc;
    req = 3'b001;
    dir = 3'b001;
    push_burst(k + LAT, 3'b001, 6'b000001, B);
    wait_until(k + LAT + B);
    req = '0;
    expect_idle("basic_idle_after");

    // Round-robin from pointer 0 with all lanes requesting.
    rst = 1'b1;
    wait_until(cyc + 1);
    rst = 1'b0;
    k = cyc;
    req = 3'b111;
    dir = 3'b101;
    push_burst(k + LAT,               3'b001, 6'b000001, B);
    push_burst(k + LAT + (B + LAT),   3'b010, 6'b001000, B);
    push_burst(k + LAT + 2*(B + LAT), 3'b100, 6'b010000, B);
    push_burst(k + LAT + 3*(B + LAT), 3'b001, 6'b000001, B);
    wait_until(k + LAT + 3*(B + LAT) + B);
    req = '0;
    expect_idle("rr_idle_after");

    // Early termination of lane 1 (port drives lane) after two beats.
    k = cyc;
    req = 3'b010;
    dir = 3'b000;
    s = k + LAT;
    push_burst(s, 3'b010, 6'b001000, 2);
    wait_until(s + 1);
    req = '0;

    // Pointer must now be 2: lane 2 wins although all lanes request.
    wait_until(s + 2);
    req = 3'b111;
    dir = 3'b111;
    s2 = cyc + LAT;
    push_burst(s2, 3'b100, 6'b010000, 3);
    wait_until(s2 + 2);
    rst = 1'b1;
    req = 3'b100;
    dir = 3'b100;
    wait_until(s2 + 3);
    rst = 1'b0;
    s3 = cyc + LAT;
    push_burst(s3, 3'b100, 6'b010000, B);
    expect_idle("mid_burst_reset");

    // dir toggles throughout the burst; the granted code must not move.
    for (int i = 0; i < (s3 + B) - (s2 + 4); i++) begin
      dir = dir ^ 3'b111;
      @(posedge clk);
      #1;
    end
    req = '0;
    expect_idle("dir_toggle_idle_after");

    // Lane 1 driving port, from pointer 0.
    k = cyc;
    req = 3'b010;
    dir = 3'b010;
    s = k + LAT;
    push_burst(s, 3'b010, 6'b000100, B);
    wait_until(s + B);
    req = '0;
    expect_idle("lane1_idle_after");

    wait_until(cyc + 3);
    check("queue_drained", exp_q.size() == 0, $sformatf("%0d beats left", exp_q.size()), "0 beats left");
    check("select_legal", illegal == 0, $sformatf("%0d illegal cycles", illegal), "0 illegal cycles");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
